// File: rtl/vp_pkg.sv
// Shared types and constants for the video-path frame mux and line filler.
package vp_pkg;

  // Line filler states: pass-through of the selected stream, or padding a short line.
  typedef enum logic [0:0] {
    PASS = 1'b0,
    FILL = 1'b1
  } vp_state_e;

  // Common padding colours for 24-bit RGB.
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;

  // Ceiling log2, used to size the channel select from the channel count.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vp_line_filler.sv
// Output stage of the frame mux: registers the selected stream, counts
// output pixels per line, pads short lines with a fill colour and keeps
// sticky flags for over-long lines and lines that start during padding.
module vp_line_filler
  import vp_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int H_DISP = 1280,
  parameter int X_W    = 11,
  parameter logic [DATA_W-1:0] FILL_COLOR = DATA_W'(BLACK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_on,
  input  logic              vs_rise,
  input  logic              sel_vs,
  input  logic              sel_de,
  input  logic [DATA_W-1:0] sel_data,
  input  logic              err_clr,
  output logic              out_vs,
  output logic              out_de,
  output logic [DATA_W-1:0] out_data,
  output logic              err_long,
  output logic              err_overrun
);

  localparam logic [X_W-1:0]    X_MAX  = X_W'(H_DISP);
  localparam logic [X_W-1:0]    X_ONE  = {{(X_W-1){1'b0}}, 1'b1};
  localparam logic [X_W-1:0]    X_ZERO = {X_W{1'b0}};
  localparam logic [DATA_W-1:0] D_ZERO = {DATA_W{1'b0}};

  vp_state_e         state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [X_W-1:0]    x_inc_s;
  logic              out_vs_q, out_vs_d;
  logic              out_de_q, out_de_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              err_long_q, err_long_d;
  logic              err_overrun_q, err_overrun_d;
  logic              long_set_s;
  logic              ovr_set_s;

  // Next-state, pixel counter and output selection for pass/pad behaviour.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    x_inc_s    = x_q + X_ONE;
    out_vs_d   = sel_vs;
    out_de_d   = 1'b0;
    out_data_d = D_ZERO;
    long_set_s = 1'b0;
    ovr_set_s  = 1'b0;
    case (state_q)
      PASS: begin
        if (sel_de) begin
          if (x_q < X_MAX) begin
            out_de_d   = 1'b1;
            out_data_d = sel_data;
            x_d        = x_inc_s;
          end else begin
            // Line already full: drop the surplus until de falls.
            long_set_s = 1'b1;
          end
        end else if (fill_on && (x_q != X_ZERO) && (x_q < X_MAX)) begin
          // de just fell on a short line: first fill pixel goes out now.
          out_de_d   = 1'b1;
          out_data_d = FILL_COLOR;
          x_d        = x_inc_s;
          if (x_inc_s == X_MAX) begin
            state_d = PASS;
          end else begin
            state_d = FILL;
          end
        end else begin
          x_d = X_ZERO;
        end
      end
      FILL: begin
        if (vs_rise) begin
          // New frame: abandon padding quietly.
          state_d = PASS;
          x_d     = X_ZERO;
        end else if (sel_de) begin
          // Next line arrived before padding completed: pass it straight on.
          ovr_set_s  = 1'b1;
          out_de_d   = 1'b1;
          out_data_d = sel_data;
          x_d        = X_ONE;
          state_d    = PASS;
        end else begin
          out_de_d   = 1'b1;
          out_data_d = FILL_COLOR;
          x_d        = x_inc_s;
          if (x_inc_s == X_MAX) begin
            state_d = PASS;
          end else begin
            state_d = FILL;
          end
        end
      end
      default: begin
        state_d = PASS;
        x_d     = X_ZERO;
      end
    endcase
  end

  // Sticky error flags; clear wins over a simultaneous set.
  always_comb begin
    if (err_clr) begin
      err_long_d    = 1'b0;
      err_overrun_d = 1'b0;
    end else begin
      err_long_d    = err_long_q | long_set_s;
      err_overrun_d = err_overrun_q | ovr_set_s;
    end
  end

  // State, counter, output and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= PASS;
      x_q           <= X_ZERO;
      out_vs_q      <= 1'b0;
      out_de_q      <= 1'b0;
      out_data_q    <= D_ZERO;
      err_long_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      out_vs_q      <= out_vs_d;
      out_de_q      <= out_de_d;
      out_data_q    <= out_data_d;
      err_long_q    <= err_long_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign out_vs      = out_vs_q;
  assign out_de      = out_de_q;
  assign out_data    = out_data_q;
  assign err_long    = err_long_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: rtl/vp_frame_mux.sv
// N-channel video stream selector. A new selection is only taken at the
// vsync rising edge of the channel currently on air, so frames never tear.
// The selected stream is handed to vp_line_filler for registering/padding.
module vp_frame_mux
  import vp_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2(NUM_CH),
  parameter int DATA_W = 24,
  parameter int H_DISP = 1280,
  parameter int X_W    = 11,
  parameter logic [DATA_W-1:0] FILL_COLOR = DATA_W'(BLACK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SEL_W-1:0]         sel_i,
  input  logic                     fill_en,
  input  logic [NUM_CH-1:0]        in_vs,
  input  logic [NUM_CH-1:0]        in_de,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_vs,
  output logic                     out_de,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     switch_pulse,
  output logic                     err_long,
  output logic                     err_overrun,
  input  logic                     err_clr
);

  logic [SEL_W-1:0]  active_sel_q, active_sel_d;
  logic              fill_latch_q, fill_latch_d;
  logic [NUM_CH-1:0] vs_hist_q, vs_hist_d;
  logic              switch_pulse_q, switch_pulse_d;

  logic [NUM_CH-1:0] ch_hot_s;
  logic              sel_vs_s;
  logic              sel_vs_prev_s;
  logic              sel_de_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              vs_rise_s;
  logic              sel_valid_s;

  // AND-OR channel mux driven by a one-hot decode of the active channel.
  always_comb begin
    ch_hot_s   = {NUM_CH{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      ch_hot_s[k] = (active_sel_q == SEL_W'(k));
      sel_data_s  = sel_data_s | (in_data[k*DATA_W +: DATA_W] & {DATA_W{ch_hot_s[k]}});
    end
    sel_vs_s      = |(in_vs & ch_hot_s);
    sel_vs_prev_s = |(vs_hist_q & ch_hot_s);
    sel_de_s      = |(in_de & ch_hot_s);
    vs_rise_s     = sel_vs_s & ~sel_vs_prev_s;
    sel_valid_s   = ({1'b0, sel_i} < (SEL_W+1)'(NUM_CH));
  end

  // Frame-boundary switch: latch select and fill mode on the active vsync rise.
  always_comb begin
    vs_hist_d      = in_vs;
    active_sel_d   = active_sel_q;
    fill_latch_d   = fill_latch_q;
    switch_pulse_d = 1'b0;
    if (vs_rise_s) begin
      fill_latch_d = fill_en;
      if (sel_valid_s && (sel_i != active_sel_q)) begin
        active_sel_d   = sel_i;
        switch_pulse_d = 1'b1;
      end else begin
        active_sel_d   = active_sel_q;
        switch_pulse_d = 1'b0;
      end
    end else begin
      switch_pulse_d = 1'b0;
    end
  end

  // Selection, fill mode and vsync history registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_sel_q   <= {SEL_W{1'b0}};
      fill_latch_q   <= 1'b0;
      vs_hist_q      <= {NUM_CH{1'b0}};
      switch_pulse_q <= 1'b0;
    end else begin
      active_sel_q   <= active_sel_d;
      fill_latch_q   <= fill_latch_d;
      vs_hist_q      <= vs_hist_d;
      switch_pulse_q <= switch_pulse_d;
    end
  end

  vp_line_filler #(
    .DATA_W     (DATA_W),
    .H_DISP     (H_DISP),
    .X_W        (X_W),
    .FILL_COLOR (FILL_COLOR)
  ) u_filler (
    .clk         (clk),
    .rst         (rst),
    .fill_on     (fill_latch_q),
    .vs_rise     (vs_rise_s),
    .sel_vs      (sel_vs_s),
    .sel_de      (sel_de_s),
    .sel_data    (sel_data_s),
    .err_clr     (err_clr),
    .out_vs      (out_vs),
    .out_de      (out_de),
    .out_data    (out_data),
    .err_long    (err_long),
    .err_overrun (err_overrun)
  );

  assign active_sel   = active_sel_q;
  assign switch_pulse = switch_pulse_q;

endmodule

// File: doc/vp_frame_mux.md
Name: vp_frame_mux

Overview:
- Parametrised successor to the video-path output mode selector: an N-channel stream selector with frame-safe switching and horizontal blank filling.
- Selects one of NUM_CH synchronous video streams (vs/de/data) and switches only at a frame boundary, so the display never sees a torn frame.
- When fill is enabled, each short active line is padded to H_DISP pixels with a fill colour, as used for downscaled output.
- Sits between the processing stages (scaler, edge detector, binariser, bypass) and the display/FIFO interface, in the processed-video clock domain.

Parameters:
- NUM_CH, 4, number of input streams (2..8).
- SEL_W, 2, width of select, equal to clog2(NUM_CH).
- DATA_W, 24, pixel width.
- H_DISP, 1280, target active pixels per line.
- X_W, 11, pixel counter width; must hold H_DISP.
- FILL_COLOR, 24'h000000, padding pixel value (DATA_W bits).

Ports:
- clk  in  1  processing clock; all inputs are synchronous to it.
- rst  in  1  synchronous, active-high reset.
- sel_i  in  SEL_W  requested channel; sampled every cycle.
- fill_en  in  1  enables horizontal padding; sampled with sel at the switch point.
- in_vs  in  NUM_CH  per-channel vsync, active-high, rising edge = frame start.
- in_de  in  NUM_CH  per-channel data enable.
- in_data  in  NUM_CH*DATA_W  per-channel pixels; channel k occupies bits [k*DATA_W +: DATA_W].
- out_vs  out  1  selected vsync, registered.
- out_de  out  1  output data enable, including fill pixels.
- out_data  out  DATA_W  output pixel.
- active_sel  out  SEL_W  channel currently driving the outputs.
- switch_pulse  out  1  one-cycle pulse when a new selection takes effect.
- err_long  out  1  sticky: a selected line exceeded H_DISP pixels.
- err_overrun  out  1  sticky: a new line started before padding finished.
- err_clr  in  1  clears both sticky error flags.

Behaviour:
- Reset: all outputs 0, active_sel=0, fill enable latch=0, state=PASS, pixel counter=0.
- Datapath latency: 1 cycle. out_* at cycle t+1 reflect the selected channel's inputs at cycle t.
- Frame-safe switch:
  - At a rising edge of in_vs[active_sel], the block latches sel_i and fill_en.
  - out_vs for that edge still comes from the old channel.
  - From the next cycle, active_sel takes the new value and switch_pulse=1 for one cycle.
  - sel_i values >= NUM_CH are ignored; the current channel is kept.
- Pixel counter x: increments on each output de cycle (real or fill) and resets to 0 when out_de falls.
- States:
  - PASS: out_de=in_de, out_data=in_data of the selected channel.
  - When x reaches H_DISP with in_de still high: the extra pixels are dropped (out_de=0, out_data=0), err_long is set, and the block stays in PASS until in_de falls.
  - PASS->FILL: in_de falls, fill latch=1, and 0 < x < H_DISP.
  - FILL: out_de=1, out_data=FILL_COLOR, until x==H_DISP, then back to PASS.
  - FILL->PASS early: if the selected in_de rises during FILL, padding stops immediately, err_overrun is set, and the new line's first pixel is output that cycle with x restarted at 1.
- A line of exactly H_DISP pixels, or fill latch=0, causes no padding.
- A de pulse of 0 length produces nothing; a line with x==0 at de fall is not padded.
- A vs rise during FILL aborts padding and returns to PASS with no error; a switch applied there takes effect as normal.
- out_data is 0 whenever out_de=0.
- err_clr has priority over a simultaneous set.
- rst mid-line: outputs go to 0 in the next cycle and the partial line is discarded.

Decomposition:
- Shared package vp_pkg:
  - state enum {PASS, FILL}
  - default FILL_COLOR constants BLACK and WHITE
  - the clog2 helper used for SEL_W
- One natural sub-module: vp_line_filler, which holds the counter, the FILL state machine and the error flags.
- vp_frame_mux itself holds the channel mux and the switch logic.

Test Plan (NUM_CH=4, H_DISP=8, DATA_W=24):
- Switch: sel_i changes 0->2 in mid-frame -> outputs stay on channel 0 until in_vs[0] rises; the next cycle active_sel=2, switch_pulse=1 for one cycle, and ch2 data appears 1 cycle after its input.
- Padding: fill_en=1, selected line of 5 pixels then 10 blank cycles -> out_de high 8 cycles; pixels 6..8 = 24'h000000; err flags stay 0.
- Long line: 11-pixel line -> exactly 8 output pixels; err_long=1 and stays set until err_clr is pulsed.
- Overrun: 5-pixel line with a 1-cycle gap before the next line -> one fill pixel, then the next line passes through; err_overrun=1.
- Bypass: fill_en=0, 5-pixel line -> 5 output pixels, no padding; invalid sel_i=3'b1xx is ignored (NUM_CH=4 generic run with SEL_W=3).
- Reset: assert rst during FILL -> next cycle out_de=0, out_vs=0, active_sel=0, errors=0.
